crono_timer_hms: RTL and testbench
==================================

# crono_timer_hms

Parametrised hours:minutes:seconds countdown timer for the clock/chronometer datapath. It generalises the single-field adjustable minutes counter into three chained fields with a per-field set mode, configurable wrap/saturate adjustment, a run mode driven by an external 1 Hz tick with borrow propagation, and a done indication at 00:00:00. Outputs feed the display formatter and alarm logic directly.

## Interface
Parameters:
- HOUR_MAX, 23, highest hour value (inclusive)
- HOUR_W, 5, width of hour field; must hold HOUR_MAX
- SET_WRAP, 1, 1: adjustment wraps (max+1→0, 0−1→max); 0: adjustment saturates at 0 and max

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- tick  in  1  one-cycle pulse, 1 Hz time base
- field_sel  in  2  0 none, 1 seconds, 2 minutes, 3 hours
- aumento  in  1  increment selected field (one step per cycle high)
- disminuye  in  1  decrement selected field (one step per cycle high)
- start  in  1  begin countdown
- stop  in  1  halt countdown / clear done
- seg  out  6  seconds, 0..59
- min  out  6  minutes, 0..59
- hora  out  HOUR_W  hours, 0..HOUR_MAX
- running  out  1  high in RUN
- done  out  1  high in DONE
- done_pulse  out  1  one-cycle pulse on entry to DONE

## Operation
- States: IDLE, SET, RUN, DONE. Reset: state IDLE, seg=min=hora=0, running=done=done_pulse=0.
- IDLE: field_sel≠0 → SET; start with time≠0 → RUN; start with time=0 → stay IDLE, no done.
- SET: aumento/disminuye step the selected field only; aumento wins when both high. field_sel=0 → IDLE; start with time≠0 → RUN (takes priority over adjustment that cycle; no adjust applied).
- Adjustment range per field: seg/min 0..59, hora 0..HOUR_MAX. SET_WRAP=1 wraps; SET_WRAP=0 holds at bound. Adjustment never carries/borrows into adjacent fields.
- RUN: on tick, decrement with borrow: seg>0 → seg−1; else seg=59 and borrow min; min=0 on borrow → min=59, borrow hora. Result 00:00:00 → DONE on same edge. aumento/disminuye/field_sel ignored.
- RUN priority: stop > tick. stop → IDLE holding current value, no decrement that cycle.
- DONE: time=0, done=1. stop, start or field_sel≠0 → IDLE (done cleared).
- start and tick in same cycle from IDLE/SET: enter RUN, tick not applied; first decrement on next tick.
- rst in any state, any cycle: return to reset values on that edge; overrides all other inputs.
- Fields never hold out-of-range values.

## Timing
- All outputs registered; inputs sampled at rising clk, effect visible the following cycle.
- Adjustment: one step per clock while aumento/disminuye held (debounce/rate limiting is upstream).
- Countdown latency: fields update on the edge sampling tick.
- done_pulse: high exactly one cycle, same cycle done first goes high (cycle after the final tick sampled).
- running asserts the cycle after start accepted; deasserts the cycle after stop or reaching zero.

## Structure
- Package crono_pkg: state enum (IDLE, SET, RUN, DONE), SEC_MAX=59, MIN_MAX=59, field_sel codes (FLD_NONE, FLD_SEG, FLD_MIN, FLD_HORA).
- Sub-module crono_field (parameters MAX, W, WRAP): modulo field with inc, dec, borrow-dec inputs, borrow_out when decrementing from 0; instantiated three times. Top holds FSM, zero detect, borrow chain.

## Test plan
- Reset then field_sel=2, aumento 3 cycles → min=3; field_sel=3, aumento 24 cycles at HOUR_MAX=23 → hora=0 (SET_WRAP=1); aumento+disminuye together → +1.
- SET_WRAP=0: disminuye at seg=0 → seg stays 0; aumento at seg=59 → stays 59. SET_WRAP=1: disminuye at seg=0 → 59.
- Load 00:01:02, start, 62 ticks → 00:00:00, done=1, done_pulse one cycle, running=0; 61st tick leaves 00:00:01 with done=0.
- Borrow: 01:00:00 running, one tick → 00:59:59; aumento during RUN has no effect.
- stop and tick same cycle at 00:00:10 → IDLE, value 00:00:10; start → resumes, next tick → 00:00:09. start at 00:00:00 → stays IDLE, done=0.
- rst mid-RUN at 00:05:00 → next cycle all zero, IDLE, running=0, done=0.

Source files
------------

// File: rtl/crono_pkg.sv
// Shared types and constants for the hours:minutes:seconds countdown timer.
package crono_pkg;

  // Controller states, in the order IDLE, SET, RUN, DONE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SET  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Upper bounds for the seconds and minutes fields.
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  // Codes on field_sel that pick which field is being adjusted.
  localparam logic [1:0] FLD_NONE = 2'd0;
  localparam logic [1:0] FLD_SEG  = 2'd1;
  localparam logic [1:0] FLD_MIN  = 2'd2;
  localparam logic [1:0] FLD_HORA = 2'd3;

endpackage

// File: rtl/crono_field.sv
// One modulo time field (seconds, minutes or hours).
// inc_i/dec_i are user adjustments that obey WRAP; bdec_i is the countdown
// decrement, which always wraps 0 -> MAX and reports that wrap on borrow_o.
// Priority when several are high: inc_i, then dec_i, then bdec_i.
module crono_field #(
  parameter int MAX  = 59,
  parameter int W    = 6,
  parameter int WRAP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         bdec_i,
  output logic [W-1:0] val_o,
  output logic         borrow_o
);

  localparam logic [W-1:0] MAXV = W'(MAX);

  logic [W-1:0] val_q;
  logic [W-1:0] val_d;

  // Next value: adjustment steps honour WRAP; the countdown step always wraps.
  always_comb begin
    val_d = val_q;
    if (inc_i) begin
      if (val_q == MAXV) val_d = (WRAP != 0) ? '0 : MAXV;
      else               val_d = val_q + 1'b1;
    end else if (dec_i) begin
      if (val_q == '0) val_d = (WRAP != 0) ? MAXV : '0;
      else             val_d = val_q - 1'b1;
    end else if (bdec_i) begin
      if (val_q == '0) val_d = MAXV;
      else             val_d = val_q - 1'b1;
    end
  end

  // Field register, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) val_q <= '0;
    else     val_q <= val_d;
  end

  assign val_o    = val_q;
  assign borrow_o = bdec_i && (val_q == '0);

endmodule

// File: rtl/crono_timer_hms.sv
// Hours:minutes:seconds countdown timer with per-field set mode, 1 Hz tick
// driven countdown with borrow chain, and done indication at 00:00:00.
// Control inputs are level-sampled on each rising clk; there is no
// valid/ready handshake: tick is a one-cycle strobe, aumento/disminuye give
// one step per cycle held, start/stop are acted on in the cycle they are seen.
module crono_timer_hms
  import crono_pkg::*;
#(
  parameter int HOUR_MAX = 23,
  parameter int HOUR_W   = 5,
  parameter int SET_WRAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [1:0]        field_sel,
  input  logic              aumento,
  input  logic              disminuye,
  input  logic              start,
  input  logic              stop,
  output logic [5:0]        seg,
  output logic [5:0]        min,
  output logic [HOUR_W-1:0] hora,
  output logic              running,
  output logic              done,
  output logic              done_pulse,
  output state_t            state_dbg
);

  state_t state_q, state_d;
  logic   running_q, done_q, done_pulse_q;

  logic   adj_en;     // SET adjustment allowed this cycle
  logic   cnt_en;     // countdown decrement this cycle
  logic   time_zero;
  logic   last_sec;   // value is 00:00:01, so this decrement reaches zero

  logic   inc_seg, dec_seg, inc_min, dec_min, inc_hora, dec_hora;
  logic   borrow_seg, borrow_min, borrow_hora;

  assign time_zero = (seg == '0) && (min == '0) && (hora == '0);
  assign last_sec  = (seg == 6'd1) && (min == '0) && (hora == '0);

  // Next-state logic and adjust/countdown enables.
  always_comb begin
    state_d = state_q;
    adj_en  = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (field_sel != FLD_NONE)     state_d = SET;
        else if (start && !time_zero)  state_d = RUN;
      end
      SET: begin
        // A valid start wins over any adjustment requested in the same cycle.
        if (start && !time_zero)         state_d = RUN;
        else if (field_sel == FLD_NONE)  state_d = IDLE;
        else                             adj_en  = 1'b1;
      end
      RUN: begin
        // stop beats tick: the value freezes without a final decrement.
        if (stop) begin
          state_d = IDLE;
        end else if (tick) begin
          cnt_en = 1'b1;
          if (last_sec) state_d = DONE;
        end
      end
      DONE: begin
        if (stop || start || (field_sel != FLD_NONE)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-field adjust strobes; aumento wins when both buttons are held.
  always_comb begin
    inc_seg  = adj_en && (field_sel == FLD_SEG)  && aumento;
    dec_seg  = adj_en && (field_sel == FLD_SEG)  && !aumento && disminuye;
    inc_min  = adj_en && (field_sel == FLD_MIN)  && aumento;
    dec_min  = adj_en && (field_sel == FLD_MIN)  && !aumento && disminuye;
    inc_hora = adj_en && (field_sel == FLD_HORA) && aumento;
    dec_hora = adj_en && (field_sel == FLD_HORA) && !aumento && disminuye;
  end

  crono_field #(.MAX(SEC_MAX), .W(6), .WRAP(SET_WRAP)) u_seg (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (inc_seg),
    .dec_i    (dec_seg),
    .bdec_i   (cnt_en),
    .val_o    (seg),
    .borrow_o (borrow_seg)
  );

  crono_field #(.MAX(MIN_MAX), .W(6), .WRAP(SET_WRAP)) u_min (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (inc_min),
    .dec_i    (dec_min),
    .bdec_i   (borrow_seg),
    .val_o    (min),
    .borrow_o (borrow_min)
  );

  crono_field #(.MAX(HOUR_MAX), .W(HOUR_W), .WRAP(SET_WRAP)) u_hora (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (inc_hora),
    .dec_i    (dec_hora),
    .bdec_i   (borrow_min),
    .val_o    (hora),
    .borrow_o (borrow_hora)
  );

  // State and status registers; status is decoded from the next state so it
  // lines up with the state it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      running_q    <= (state_d == RUN);
      done_q       <= (state_d == DONE);
      done_pulse_q <= (state_q == RUN) && (state_d == DONE);
    end
  end

  assign running    = running_q;
  assign done       = done_q;
  assign done_pulse = done_pulse_q;
  assign state_dbg  = state_q;

  // The hour field never borrows in practice (countdown stops at zero).
  logic unused_borrow;
  assign unused_borrow = borrow_hora;

endmodule

// File: tb/tb_crono_timer_hms.sv
// Bench for crono_timer_hms: one wrapping and one saturating instance share
// the same stimulus; a time-in-seconds model predicts both every cycle.
module tb_crono_timer_hms;

  localparam int HMAX = 23;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [1:0] field_sel = 2'd0;
  logic       aumento = 1'b0;
  logic       disminuye = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;

  logic [5:0] seg_a, min_a, seg_b, min_b;
  logic [4:0] hora_a, hora_b;
  logic       run_a, done_a, dp_a, run_b, done_b, dp_b;
  crono_pkg::state_t st_a, st_b;

  crono_timer_hms #(.HOUR_MAX(HMAX), .HOUR_W(5), .SET_WRAP(1)) dut (
    .clk(clk), .rst(rst), .tick(tick), .field_sel(field_sel),
    .aumento(aumento), .disminuye(disminuye), .start(start), .stop(stop),
    .seg(seg_a), .min(min_a), .hora(hora_a), .running(run_a),
    .done(done_a), .done_pulse(dp_a), .state_dbg(st_a)
  );

  crono_timer_hms #(.HOUR_MAX(HMAX), .HOUR_W(5), .SET_WRAP(0)) dut_sat (
    .clk(clk), .rst(rst), .tick(tick), .field_sel(field_sel),
    .aumento(aumento), .disminuye(disminuye), .start(start), .stop(stop),
    .seg(seg_b), .min(min_b), .hora(hora_b), .running(run_b),
    .done(done_b), .done_pulse(dp_b), .state_dbg(st_b)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Mode codes: 0 idle, 1 set, 2 counting, 3 finished. Time kept as total seconds.
  int m_mode[2];
  int m_t[2];
  int m_dp[2];
  int m_wrap[2] = '{1, 0};

  function automatic int adj(input int v, input int mx, input int up, input int wrap);
    if (up != 0) return (v == mx) ? ((wrap != 0) ? 0 : mx) : v + 1;
    return (v == 0) ? ((wrap != 0) ? mx : 0) : v - 1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int h, m, s, up;
      m_dp[i] = 0;
      if (rst) begin
        m_mode[i] = 0;
        m_t[i]    = 0;
      end else begin
        case (m_mode[i])
          0: begin
            if (field_sel != 2'd0)        m_mode[i] = 1;
            else if (start && m_t[i] > 0) m_mode[i] = 2;
          end
          1: begin
            if (start && m_t[i] > 0)      m_mode[i] = 2;
            else if (field_sel == 2'd0)   m_mode[i] = 0;
            else if (aumento || disminuye) begin
              h  = m_t[i] / 3600;
              m  = (m_t[i] / 60) % 60;
              s  = m_t[i] % 60;
              up = aumento ? 1 : 0;
              if (field_sel == 2'd1)      s = adj(s, 59, up, m_wrap[i]);
              else if (field_sel == 2'd2) m = adj(m, 59, up, m_wrap[i]);
              else                        h = adj(h, HMAX, up, m_wrap[i]);
              m_t[i] = h * 3600 + m * 60 + s;
            end
          end
          2: begin
            if (stop) m_mode[i] = 0;
            else if (tick) begin
              m_t[i] = m_t[i] - 1;
              if (m_t[i] == 0) begin
                m_mode[i] = 3;
                m_dp[i]   = 1;
              end
            end
          end
          default: begin
            if (stop || start || field_sel != 2'd0) m_mode[i] = 0;
          end
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic cmp(input int i, input int s, input int m, input int h,
                     input int r, input int d, input int p);
    check(i == 0 ? "wrap_seg"  : "sat_seg",  s, m_t[i] % 60);
    check(i == 0 ? "wrap_min"  : "sat_min",  m, (m_t[i] / 60) % 60);
    check(i == 0 ? "wrap_hora" : "sat_hora", h, m_t[i] / 3600);
    check(i == 0 ? "wrap_running" : "sat_running", r, (m_mode[i] == 2) ? 1 : 0);
    check(i == 0 ? "wrap_done" : "sat_done", d, (m_mode[i] == 3) ? 1 : 0);
    check(i == 0 ? "wrap_done_pulse" : "sat_done_pulse", p, m_dp[i]);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, int'(seg_a), int'(min_a), int'(hora_a), int'(run_a), int'(done_a), int'(dp_a));
      cmp(1, int'(seg_b), int'(min_b), int'(hora_b), int'(run_b), int'(done_b), int'(dp_b));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [1:0] sel, input logic au, input logic dis,
                       input logic st, input logic sp, input logic tk, input int n);
    field_sel = sel; aumento = au; disminuye = dis;
    start = st; stop = sp; tick = tk;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, n);
  endtask

  task automatic do_reset();
    idle(0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
    check("reset_seg", int'(seg_a), 0);
    check("reset_hora", int'(hora_a), 0);
    check("reset_running", int'(run_a), 0);

    // Minutes +3
    drive(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    drive(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    check("set_min_3", int'(min_a), 3);

    // Hours +24: wrap lands on 0, saturate holds 23
    drive(2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24);
    check("hora_wrap_0", int'(hora_a), 0);
    check("hora_sat_23", int'(hora_b), 23);

    // Both buttons: increment wins
    drive(2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    check("both_inc_wins", int'(hora_a), 1);

    // Seconds below zero and above 59
    drive(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    check("seg_wrap_59", int'(seg_a), 59);
    check("seg_sat_0", int'(seg_b), 0);
    drive(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 61);
    check("seg_sat_59", int'(seg_b), 59);
    check("seg_wrap_0", int'(seg_a), 0);
    check("min_untouched", int'(min_a), 3);

    // Load 00:01:02, count to zero
    do_reset();
    drive(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    drive(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    drive(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    idle(1);
    drive(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    check("run_after_start", int'(run_a), 1);
    for (int k = 0; k < 61; k++) begin
      drive(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
      idle(1);
    end
    check("tick61_seg", int'(seg_a), 1);
    check("tick61_done", int'(done_a), 0);
    drive(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    check("final_done", int'(done_a), 1);
    check("final_pulse", int'(dp_a), 1);
    check("final_running", int'(run_a), 0);
    idle(1);
    check("pulse_one_cycle", int'(dp_a), 0);
    check("done_held", int'(done_a), 1);
    drive(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    check("stop_clears_done", int'(done_a), 0);

    // Borrow across all fields: 01:00:00 -> 00:59:59, aumento ignored in RUN
    do_reset();
    drive(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    drive(2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    idle(1);
    drive(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    drive(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    check("borrow_hora", int'(hora_a), 0);
    check("borrow_min", int'(min_a), 59);
    check("borrow_seg", int'(seg_a), 59);
    drive(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    check("aumento_in_run", int'(seg_a), 59);
    drive(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);

    // stop+tick together, start+tick together
    do_reset();
    drive(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    drive(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10);
    idle(1);
    drive(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
    check("start_tick_no_dec", int'(seg_a), 10);
    drive(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    check("stop_tick_hold", int'(seg_a), 10);
    check("stop_running", int'(run_a), 0);
    drive(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    drive(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    check("resume_seg_9", int'(seg_a), 9);
    drive(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);

    // start at zero does nothing
    do_reset();
    drive(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    check("start_zero_run", int'(run_a), 0);
    check("start_zero_done", int'(done_a), 0);

    // reset in the middle of a countdown
    do_reset();
    drive(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    drive(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    idle(1);
    drive(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    check("pre_rst_min", int'(min_a), 5);
    rst = 1'b1;
    drive(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    rst = 1'b0;
    check("rst_run_min", int'(min_a), 0);
    check("rst_run_running", int'(run_a), 0);
    check("rst_run_done", int'(done_a), 0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
